// File: rtl/digit_seq_pkg.sv
// Shared types and wrap arithmetic for the digit sequencer.
package digit_seq_pkg;

    localparam int unsigned CODE_W = 3;

    typedef logic [CODE_W-1:0] code_t;

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // One step up or down, wrapping between 0 and max.
    function automatic code_t next_code(input code_t code, input logic dir, input code_t max);
        code_t res;
        if (!dir) begin
            res = (code == max) ? code_t'(0) : code + code_t'(1);
        end else begin
            res = (code == code_t'(0)) ? max : code - code_t'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stable-level debounce counter and one-cycle rising-edge pulse.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count cycles the synchronized level disagrees with the accepted level; flip when long enough.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = ~level_q;
            cnt_d   = '0;
            pulse_d = ~level_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset discards any partial debounce window.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/digit_sequencer.sv
// 3-bit code generator: auto-steps in RUN, button-steps in PAUSE, with load and wrap.
module digit_sequencer
    import digit_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV        = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned MAX_CODE        = 7
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              step_btn,
    input  logic              run_en,
    input  logic              dir,
    input  logic              load,
    input  logic [CODE_W-1:0] load_val,
    output logic [CODE_W-1:0] code,
    output logic              changed,
    output logic              running
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam code_t       MAX_V = CODE_W'(MAX_CODE);

    logic             step_pulse;
    logic [1:0]       run_sync_q;
    state_e           state_q;
    logic             running_q;
    logic [PRE_W-1:0] presc_q, presc_d;
    code_t            code_q, code_d;
    logic             changed_q, changed_d;
    logic             tick_c, adv_c;
    code_t            load_clamped_c;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_deb (
        .clk_i  (CLOCK_50),
        .rst_i  (reset),
        .btn_i  (step_btn),
        .pulse_o(step_pulse)
    );

    // Synchronize the run switch into the clock domain.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            run_sync_q <= '0;
        end else begin
            run_sync_q <= {run_sync_q[0], run_en};
        end
    end

    // PAUSE/RUN mode FSM with registered running flag.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                ST_PAUSE: if (run_sync_q[1]) begin
                    state_q   <= ST_RUN;
                    running_q <= 1'b1;
                end
                ST_RUN: if (!run_sync_q[1]) begin
                    state_q   <= ST_PAUSE;
                    running_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_PAUSE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    // Advance selection, prescaler and code next-state; load outranks advance.
    always_comb begin
        tick_c         = (state_q == ST_RUN) && (presc_q == PRE_W'(TICK_DIV - 1));
        adv_c          = (state_q == ST_RUN) ? tick_c : step_pulse;
        load_clamped_c = (load_val > MAX_V) ? MAX_V : load_val;
        presc_d        = '0;
        code_d         = code_q;
        changed_d      = 1'b0;
        if (state_q == ST_RUN && !tick_c && !load) begin
            presc_d = presc_q + PRE_W'(1);
        end
        if (load) begin
            code_d    = load_clamped_c;
            changed_d = 1'b1;
        end else if (adv_c) begin
            code_d    = next_code(code_q, dir, MAX_V);
            changed_d = 1'b1;
        end
    end

    // Prescaler, code and change-pulse registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            presc_q   <= '0;
            code_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            code_q    <= code_d;
            changed_q <= changed_d;
        end
    end

    assign code    = code_q;
    assign changed = changed_q;
    assign running = running_q;

endmodule

// File: tb/tb_digit_sequencer.sv
// Randomized and directed bench for digit_sequencer against a cycle-level reference model.
module tb_digit_sequencer;

    localparam int TD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step_btn = 1'b0;
    logic       run_en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;

    logic [2:0] code7, code5;
    logic       changed7, changed5, running7, running5;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (index 0: MAX_CODE=7, index 1: MAX_CODE=5).
    int m_max[2] = '{7, 5};
    int m_code[2] = '{0, 0};
    int m_chg[2] = '{0, 0};
    int m_run = 0;
    int m_presc = 0;
    int m_r1 = 0, m_r2 = 0, m_b1 = 0, m_b2 = 0;
    int m_lvl = 0, m_cnt = 0, m_pulse = 0;

    always #5 clk = ~clk;

    digit_sequencer #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .MAX_CODE(7)) dut7 (
        .CLOCK_50(clk), .reset(reset), .step_btn(step_btn), .run_en(run_en), .dir(dir),
        .load(load), .load_val(load_val), .code(code7), .changed(changed7), .running(running7)
    );

    digit_sequencer #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .MAX_CODE(5)) dut5 (
        .CLOCK_50(clk), .reset(reset), .step_btn(step_btn), .run_en(run_en), .dir(dir),
        .load(load), .load_val(load_val), .code(code5), .changed(changed5), .running(running5)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply the rules for one clock edge using the inputs present at that edge.
    task automatic model_step();
        int adv, np;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_code[k] = 0;
                m_chg[k]  = 0;
            end
            m_run = 0; m_presc = 0;
            m_r1 = 0; m_r2 = 0; m_b1 = 0; m_b2 = 0;
            m_lvl = 0; m_cnt = 0; m_pulse = 0;
        end else begin
            adv = m_run ? int'(m_presc == TD - 1) : m_pulse;
            for (int k = 0; k < 2; k++) begin
                if (load) begin
                    m_code[k] = (int'(load_val) > m_max[k]) ? m_max[k] : int'(load_val);
                end else if (adv != 0) begin
                    if (dir) m_code[k] = (m_code[k] + m_max[k]) % (m_max[k] + 1);
                    else     m_code[k] = (m_code[k] + 1) % (m_max[k] + 1);
                end
                m_chg[k] = (load || adv != 0) ? 1 : 0;
            end
            if (load || m_run == 0) m_presc = 0;
            else m_presc = (m_presc + 1) % TD;
            np = 0;
            if (m_b2 != m_lvl) begin
                m_cnt++;
                if (m_cnt == DB) begin
                    m_lvl = 1 - m_lvl;
                    m_cnt = 0;
                    np = m_lvl;
                end
            end else begin
                m_cnt = 0;
            end
            m_pulse = np;
            m_run = m_r2;
            m_r2 = m_r1; m_r1 = int'(run_en);
            m_b2 = m_b1; m_b1 = int'(step_btn);
        end
    endtask

    task automatic compare_all();
        chk("code7", int'(code7), m_code[0]);
        chk("chg7", int'(changed7), m_chg[0]);
        chk("run7", int'(running7), m_run);
        chk("code5", int'(code5), m_code[1]);
        chk("chg5", int'(changed5), m_chg[1]);
        chk("run5", int'(running5), m_run);
    endtask

    // Inputs are set before calling; sample on the falling edge after the update.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    // Run until the model prescaler reaches a value in RUN, bounded.
    task automatic wait_presc(input int target, input string tag);
        int n = 0;
        while (!(m_run == 1 && m_presc == target) && n < 20) begin
            cycle();
            n++;
        end
        if (n >= 20) chk(tag, m_presc, target);
    endtask

    initial begin
        int n;
        int held;

        // Reset state.
        cycles(2);
        reset = 1'b0;
        chk("rst_code", int'(code7), 0);
        chk("rst_running", int'(running7), 0);
        chk("rst_changed", int'(changed7), 0);

        // Down from 0: first step wraps to MAX_CODE; run_en sampled at edge 1, RUN after edge 3, tick 4 later.
        run_en = 1'b1; dir = 1'b1;
        n = 0;
        while (changed7 !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        chk("first_step_lat", n, 7);
        chk("down_wrap7", int'(code7), 7);
        chk("down_wrap5", int'(code5), 5);
        cycles(TD);
        chk("down_next7", int'(code7), 6);

        // Up count through a full wrap.
        do_reset();
        dir = 1'b0;
        cycles(45);
        chk("up_running", int'(running7), 1);

        // Load coinciding with a tick wins over the advance.
        wait_presc(TD - 1, "wait_tick_a");
        load = 1'b1; load_val = 3'd6;
        cycle();
        load = 1'b0;
        chk("load_tick7", int'(code7), 6);
        chk("load_tick5", int'(code5), 5);
        chk("load_tick_chg", int'(changed7), 1);
        cycles(3);
        load = 1'b1; load_val = 3'd7;
        cycle();
        load = 1'b0;
        chk("load_clamp5", int'(code5), 5);
        chk("load_same_chg5", int'(changed5), 1);
        cycles(10);

        // Reset mid-RUN with the prescaler at 2.
        wait_presc(2, "wait_presc2");
        do_reset();
        chk("midrst_code", int'(code7), 0);
        chk("midrst_running", int'(running7), 0);
        chk("midrst_changed", int'(changed7), 0);
        cycles(12);

        // Leave RUN at prescaler count 3; code must then hold.
        wait_presc(TD - 1, "wait_tick_b");
        run_en = 1'b0;
        n = 0;
        while (running7 !== 1'b0 && n < 10) begin
            cycle();
            n++;
        end
        chk("run_drop_lat", n, 3);
        held = int'(code7);
        cycles(20);
        chk("pause_hold", int'(code7), held);

        // PAUSE button stepping: clean press, glitch, long press.
        load = 1'b1; load_val = 3'd3;
        cycle();
        load = 1'b0;
        step_btn = 1'b1; cycles(5);
        step_btn = 1'b0; cycles(10);
        chk("press_step", int'(code7), 4);
        step_btn = 1'b1; cycles(2);
        step_btn = 1'b0; cycles(10);
        chk("glitch_none", int'(code7), 4);
        step_btn = 1'b1; cycles(100);
        step_btn = 1'b0; cycles(10);
        chk("long_press", int'(code7), 5);

        // Reset during a press: a full sync + debounce window must follow before the step.
        step_btn = 1'b1; cycles(3);
        do_reset();
        n = 0;
        while (changed7 !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        chk("deb_after_rst", n, 6);
        chk("deb_after_rst_code", int'(code7), 1);
        step_btn = 1'b0; cycles(10);

        // Button presses in RUN are ignored (model tracks ticks only).
        run_en = 1'b1; cycles(6);
        step_btn = 1'b1; cycles(6);
        step_btn = 1'b0; cycles(12);

        // Randomized phase.
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(99) == 0);
            load     = ($urandom_range(19) == 0);
            load_val = 3'($urandom_range(7));
            dir      = 1'($urandom_range(1));
            if ($urandom_range(39) == 0) run_en = ~run_en;
            if ($urandom_range(5) == 0) step_btn = ~step_btn;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
